// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait-state latency,
// byte-lane stores and extended load data. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic        commit;

  // Access fields: live bus when committing on the accept edge, captured copy otherwise
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic        acc_oor, acc_illegal, acc_misalign, acc_err;
  logic [3:0]  acc_be;
  logic [31:0] acc_wbus;
  logic [AW-1:0] acc_idx;
  logic        mem_we;
  logic [31:0] rd_word;

  always_comb begin
    acc_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    acc_we    = (state_q == IDLE) ? req_we     : we_q;
    acc_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    acc_idx   = acc_addr[AW+1:2];
    acc_oor   = |acc_addr[31:AW+2];

    acc_illegal = 1'b0;
    if (acc_we) begin
      acc_illegal = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010);
    end else begin
      acc_illegal = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010 ||
                      acc_f3 == 3'b100 || acc_f3 == 3'b101);
    end

    acc_misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (acc_f3[1:0])
      2'b01:   acc_misalign = acc_addr[0];
      2'b10:   acc_misalign = |acc_addr[1:0];
      default: acc_misalign = 1'b0;
    endcase
`endif
    acc_err = acc_oor | acc_illegal | acc_misalign;

    // Lane enables drop the low address bits that do not apply to the access size
    case (acc_f3[1:0])
      2'b00: begin
        acc_be   = 4'b0001 << acc_addr[1:0];
        acc_wbus = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        acc_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        acc_wbus = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        acc_be   = 4'b1111;
        acc_wbus = acc_wdata;
      end
      default: begin
        acc_be   = 4'b0000;
        acc_wbus = acc_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    f3_d       = f3_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          f3_d    = req_funct3;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) err_d = acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
    end
  end

  // rst gating keeps an edge seen while reset is held from writing the array
  assign mem_we = commit & acc_we & ~acc_err & ~rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (mem_we && acc_be[gi]) mem[acc_idx] <= acc_wbus[8*gi +: 8];
        if (commit) rd_q <= mem[acc_idx];
      end
      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    rd_shift = rd_word >> {addr_q[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = rd_word;
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = 32'd0;
    endcase
    resp_rdata = (state_q == RESP && !we_q && !err_q) ? ld_ext : 32'd0;
    resp_err   = (state_q == RESP) & err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-level memory model plus literal
// expectations; build with +define+DMEM_MISALIGN_TRAP_EN for the trapping variant.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  mb [DEPTH*4];
  logic        inflight = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed model of the memory and the access rules
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int n;
    logic legal;
    int base;
    logic [31:0] v;
    rd = 32'd0;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = !legal || (a >= 32'(DEPTH*4));
`ifdef DMEM_MISALIGN_TRAP_EN
    if (legal && (int'(a[1:0]) % n) != 0) err = 1'b1;
`endif
    if (err) return;
    base = int'(a) - (int'(a[1:0]) % n);
    if (we) begin
      for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
      if (!f3[2] && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endtask

  // Response checker: every cycle a response is presented it must match the model
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      chk("resp_valid_expected", {31'd0, inflight}, 32'd1);
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    end
  end

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int stall,
                      input logic [31:0] lit_rd, input logic lit_err);
    logic [31:0] e_rd;
    logic e_err;
    int edges;
    model(we, f3, a, wd, e_rd, e_err);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    exp_rdata = e_rd; exp_err = e_err; inflight = 1'b1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    edges = 1;
    while (!resp_valid && edges < 40) begin
      chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    chk("resp_arrives", {31'd0, resp_valid}, 32'd1);
    if (!resp_valid) begin
      inflight = 1'b0;
      return;
    end
    chk("latency", edges, LAT);
    chk("lit_rdata", resp_rdata, lit_rd);
    chk("lit_err", {31'd0, resp_err}, {31'd0, lit_err});
    for (int s = 0; s < stall; s++) begin
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    inflight = 1'b0;
    chk("valid_drop", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    $display("xact we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d (lat %0d)",
             we, f3, a, wd, e_rd, e_err, edges);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    xact(1'b1, 3'b000, 32'h11, 32'h000000A5, 0, 32'h0, 1'b0);
    xact(1'b0, 3'b000, 32'h11, 32'h0, 0, 32'hFFFFFFA5, 1'b0);
    xact(1'b0, 3'b100, 32'h11, 32'h0, 0, 32'h000000A5, 1'b0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADA5EF, 1'b0);
    xact(1'b1, 3'b010, 32'h20, 32'h12345678, 0, 32'h0, 1'b0);
    xact(1'b1, 3'b001, 32'h22, 32'h00008001, 0, 32'h0, 1'b0);
    xact(1'b0, 3'b001, 32'h22, 32'h0, 0, 32'hFFFF8001, 1'b0);
    xact(1'b0, 3'b101, 32'h22, 32'h0, 0, 32'h00008001, 1'b0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h80015678, 1'b0);
    xact(1'b0, 3'b001, 32'h20, 32'h0, 0, 32'h00005678, 1'b0);
    xact(1'b0, 3'b000, 32'h23, 32'h0, 0, 32'hFFFFFF80, 1'b0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 5, 32'hDEADA5EF, 1'b0);
    xact(1'b0, 3'b010, 32'h1000, 32'h0, 0, 32'h0, 1'b1);
    xact(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADA5EF, 1'b0);
    xact(1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1'b1);
    xact(1'b0, 3'b110, 32'h10, 32'h0, 0, 32'h0, 1'b1);
    xact(1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 0, 32'h0, 1'b0);
    xact(1'b0, 3'b010, 32'hFFC, 32'h0, 0, 32'hCAFEF00D, 1'b0);
    xact(1'b1, 3'b010, 32'h30, 32'h11223344, 0, 32'h0, 1'b0);

    // Store abandoned by reset while waiting; model is left untouched
    chk("req_ready_pre_rst", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    chk("async_rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset during WAIT of SW 0x30 applied");

    xact(1'b0, 3'b010, 32'h30, 32'h0, 0, 32'h11223344, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    xact(1'b0, 3'b010, 32'h31, 32'h0, 0, 32'h0, 1'b1);
    xact(1'b0, 3'b001, 32'h33, 32'h0, 0, 32'h0, 1'b1);
`else
    xact(1'b0, 3'b010, 32'h31, 32'h0, 0, 32'h11223344, 1'b0);
    xact(1'b0, 3'b001, 32'h33, 32'h0, 0, 32'h00001122, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
